// File: rtl/ysyx_24110017_axi_master.sv
// ysyx_24110017_axi_master
// Bridges a simple core request/response handshake onto an AXI4-Lite style
// master port, with one transaction in flight at a time.
//
// Ports:
//   clock, reset          - single rising-edge clock, async active-high reset
//   req_*                 - core request (valid/ready, wen, addr, size, wdata, wstrb)
//   resp_*                - core response (valid/ready, rdata, err)
//   master_aw*/w*/b*      - AXI write address, write data and write response channels
//   master_ar*/r*         - AXI read address and read data channels
//
// A per-transaction watchdog aborts any channel wait after TIMEOUT cycles and
// returns an error response with zero read data. The abort intentionally drops
// valid/ready without a handshake, so it is a debug aid rather than a legal
// AXI recovery. ID/len/burst/last signals are tied off by the instantiating top.
module ysyx_24110017_axi_master #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic        master_awready,
  output logic        master_awvalid,
  output logic [31:0] master_awaddr,
  output logic [2:0]  master_awsize,
  input  logic        master_wready,
  output logic        master_wvalid,
  output logic [31:0] master_wdata,
  output logic [3:0]  master_wstrb,
  output logic        master_bready,
  input  logic        master_bvalid,
  input  logic [1:0]  master_bresp,
  input  logic        master_arready,
  output logic        master_arvalid,
  output logic [31:0] master_araddr,
  output logic [2:0]  master_arsize,
  output logic        master_rready,
  input  logic        master_rvalid,
  input  logic [31:0] master_rdata,
  input  logic [1:0]  master_rresp
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Terminal count: the TIMEOUT-th busy cycle sees this value.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WADDR = 3'd3,
    WRESP = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             aw_done_r, aw_done_s;
  logic             w_done_r, w_done_s;
  logic [31:0]      rdata_r, rdata_s;
  logic             err_r, err_s;

  logic [31:0]      addr_r;
  logic [2:0]       size_r;
  logic [31:0]      wdata_r;
  logic [3:0]       wstrb_r;

  logic req_ready_r, arvalid_r, rready_r, awvalid_r, wvalid_r, bready_r, resp_valid_r;
  logic req_ready_s, arvalid_s, rready_s, awvalid_s, wvalid_s, bready_s, resp_valid_s;

  logic accept_s;
  logic busy_s;
  logic timeout_s;

  // Next-state, watchdog and response capture logic.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    aw_done_s = aw_done_r;
    w_done_s  = w_done_r;
    rdata_s   = rdata_r;
    err_s     = err_r;

    accept_s  = req_ready_r & req_valid;
    busy_s    = (state_r != IDLE) && (state_r != DONE);
    timeout_s = busy_s && (cnt_r == CNT_LAST);

    if (busy_s) begin
      cnt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_s = cnt_r;
    end

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          cnt_s     = {CNT_W{1'b0}};
          aw_done_s = 1'b0;
          w_done_s  = 1'b0;
          rdata_s   = 32'h0000_0000;
          err_s     = 1'b0;
          state_s   = req_wen ? WADDR : RADDR;
        end else begin
          state_s = IDLE;
        end
      end
      RADDR: begin
        if (timeout_s) begin
          state_s = DONE;
          rdata_s = 32'h0000_0000;
          err_s   = 1'b1;
        end else if (arvalid_r && master_arready) begin
          state_s = RDATA;
        end else begin
          state_s = RADDR;
        end
      end
      RDATA: begin
        if (timeout_s) begin
          state_s = DONE;
          rdata_s = 32'h0000_0000;
          err_s   = 1'b1;
        end else if (rready_r && master_rvalid) begin
          state_s = DONE;
          rdata_s = master_rdata;
          err_s   = (master_rresp != 2'b00);
        end else begin
          state_s = RDATA;
        end
      end
      WADDR: begin
        // AW and W complete independently; each valid falls after its own handshake.
        aw_done_s = aw_done_r | (awvalid_r & master_awready);
        w_done_s  = w_done_r  | (wvalid_r  & master_wready);
        if (timeout_s) begin
          state_s = DONE;
          rdata_s = 32'h0000_0000;
          err_s   = 1'b1;
        end else if (aw_done_s && w_done_s) begin
          state_s = WRESP;
        end else begin
          state_s = WADDR;
        end
      end
      WRESP: begin
        if (timeout_s) begin
          state_s = DONE;
          rdata_s = 32'h0000_0000;
          err_s   = 1'b1;
        end else if (bready_r && master_bvalid) begin
          state_s = DONE;
          rdata_s = 32'h0000_0000;
          err_s   = (master_bresp != 2'b00);
        end else begin
          state_s = WRESP;
        end
      end
      DONE: begin
        if (resp_valid_r && resp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Handshake outputs are registered, so they follow the next state.
    req_ready_s  = (state_s == IDLE);
    arvalid_s    = (state_s == RADDR);
    rready_s     = (state_s == RDATA);
    awvalid_s    = (state_s == WADDR) && !aw_done_s;
    wvalid_s     = (state_s == WADDR) && !w_done_s;
    bready_s     = (state_s == WRESP);
    resp_valid_s = (state_s == DONE);
  end

  // State, watchdog, response and handshake-output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      aw_done_r    <= 1'b0;
      w_done_r     <= 1'b0;
      rdata_r      <= 32'h0000_0000;
      err_r        <= 1'b0;
      req_ready_r  <= 1'b0;
      arvalid_r    <= 1'b0;
      rready_r     <= 1'b0;
      awvalid_r    <= 1'b0;
      wvalid_r     <= 1'b0;
      bready_r     <= 1'b0;
      resp_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      aw_done_r    <= aw_done_s;
      w_done_r     <= w_done_s;
      rdata_r      <= rdata_s;
      err_r        <= err_s;
      req_ready_r  <= req_ready_s;
      arvalid_r    <= arvalid_s;
      rready_r     <= rready_s;
      awvalid_r    <= awvalid_s;
      wvalid_r     <= wvalid_s;
      bready_r     <= bready_s;
      resp_valid_r <= resp_valid_s;
    end
  end

  // Request capture: the request bus is only sampled on the accept cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_r  <= 32'h0000_0000;
      size_r  <= 3'b000;
      wdata_r <= 32'h0000_0000;
      wstrb_r <= 4'b0000;
    end else if (accept_s) begin
      addr_r  <= req_addr;
      size_r  <= req_size;
      wdata_r <= req_wdata;
      wstrb_r <= req_wstrb;
    end else begin
      addr_r  <= addr_r;
      size_r  <= size_r;
      wdata_r <= wdata_r;
      wstrb_r <= wstrb_r;
    end
  end

  assign req_ready      = req_ready_r;
  assign resp_valid     = resp_valid_r;
  assign resp_rdata     = rdata_r;
  assign resp_err       = err_r;
  assign master_awvalid = awvalid_r;
  assign master_awaddr  = addr_r;
  assign master_awsize  = size_r;
  assign master_wvalid  = wvalid_r;
  assign master_wdata   = wdata_r;
  assign master_wstrb   = wstrb_r;
  assign master_bready  = bready_r;
  assign master_arvalid = arvalid_r;
  assign master_araddr  = addr_r;
  assign master_arsize  = size_r;
  assign master_rready  = rready_r;

endmodule

// File: tb/tb_ysyx_24110017_axi_master.sv
module tb_ysyx_24110017_axi_master;

  logic        clock;
  logic        reset;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        master_awready, master_awvalid;
  logic [31:0] master_awaddr;
  logic [2:0]  master_awsize;
  logic        master_wready, master_wvalid;
  logic [31:0] master_wdata;
  logic [3:0]  master_wstrb;
  logic        master_bready, master_bvalid;
  logic [1:0]  master_bresp;
  logic        master_arready, master_arvalid;
  logic [31:0] master_araddr;
  logic [2:0]  master_arsize;
  logic        master_rready, master_rvalid;
  logic [31:0] master_rdata;
  logic [1:0]  master_rresp;

  int checks   = 0;
  int failures = 0;

  // {req_ready, arvalid, rready, awvalid, wvalid, bready, resp_valid}
  logic [6:0] flags;
  assign flags = {req_ready, master_arvalid, master_rready, master_awvalid,
                  master_wvalid, master_bready, resp_valid};

  ysyx_24110017_axi_master #(.TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .master_awready(master_awready), .master_awvalid(master_awvalid),
    .master_awaddr(master_awaddr), .master_awsize(master_awsize),
    .master_wready(master_wready), .master_wvalid(master_wvalid),
    .master_wdata(master_wdata), .master_wstrb(master_wstrb),
    .master_bready(master_bready), .master_bvalid(master_bvalid), .master_bresp(master_bresp),
    .master_arready(master_arready), .master_arvalid(master_arvalid),
    .master_araddr(master_araddr), .master_arsize(master_arsize),
    .master_rready(master_rready), .master_rvalid(master_rvalid),
    .master_rdata(master_rdata), .master_rresp(master_rresp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
    req_wdata = wdata; req_wstrb = wstrb;
    tick;
    req_valid = 1'b0; req_addr = 32'hDEAD_BEEF; req_size = 3'd7;
    req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'hF;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (flags !== 7'b0000000) begin
      failures++; $display("FAIL reset_flags got=%b exp=%b", flags, 7'b0000000);
    end
    checks++;
    if ({resp_rdata, resp_err} !== 33'h0) begin
      failures++; $display("FAIL reset_resp got=%h exp=%h", {resp_rdata, resp_err}, 33'h0);
    end
    reset = 1'b0;
    tick;
    checks++;
    if (flags !== 7'b1000000) begin
      failures++; $display("FAIL reset_release got=%b exp=%b", flags, 7'b1000000);
    end
  endtask

  task automatic test_read;
    issue(1'b0, 32'h8000_0004, 3'd2, 32'h0, 4'h0);
    checks++;
    if ({flags, master_araddr, master_arsize} !== {7'b0100000, 32'h8000_0004, 3'd2}) begin
      failures++; $display("FAIL read_ar got=%b/%h/%0d exp=0100000/80000004/2", flags, master_araddr, master_arsize);
    end
    master_arready = 1'b1;
    tick;
    master_arready = 1'b0;
    checks++;
    if (flags !== 7'b0010000) begin
      failures++; $display("FAIL read_rdata_state got=%b exp=%b", flags, 7'b0010000);
    end
    tick; tick; tick;
    checks++;
    if (flags !== 7'b0010000) begin
      failures++; $display("FAIL read_wait_k got=%b exp=%b", flags, 7'b0010000);
    end
    master_rvalid = 1'b1; master_rdata = 32'h0010_0073; master_rresp = 2'b00;
    tick;
    master_rvalid = 1'b0; master_rdata = 32'h0;
    checks++;
    if ({flags, resp_rdata, resp_err} !== {7'b0000001, 32'h0010_0073, 1'b0}) begin
      failures++; $display("FAIL read_resp got=%b/%h/%b exp=0000001/00100073/0", flags, resp_rdata, resp_err);
    end
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    checks++;
    if (flags !== 7'b1000000) begin
      failures++; $display("FAIL read_return_idle got=%b exp=%b", flags, 7'b1000000);
    end
  endtask

  task automatic test_write;
    issue(1'b1, 32'hA000_03F8, 3'd0, 32'h0000_0041, 4'b0001);
    checks++;
    if ({flags, master_awaddr, master_awsize, master_wdata, master_wstrb} !==
        {7'b0001100, 32'hA000_03F8, 3'd0, 32'h0000_0041, 4'b0001}) begin
      failures++; $display("FAIL write_aw_w got=%b/%h/%0d/%h/%b exp=0001100/a00003f8/0/00000041/0001",
                           flags, master_awaddr, master_awsize, master_wdata, master_wstrb);
    end
    master_awready = 1'b1;
    tick;
    master_awready = 1'b0;
    checks++;
    if (flags !== 7'b0000100) begin
      failures++; $display("FAIL write_aw_first got=%b exp=%b", flags, 7'b0000100);
    end
    tick;
    checks++;
    if (flags !== 7'b0000100) begin
      failures++; $display("FAIL write_w_hold got=%b exp=%b", flags, 7'b0000100);
    end
    master_wready = 1'b1;
    tick;
    master_wready = 1'b0;
    checks++;
    if (flags !== 7'b0000010) begin
      failures++; $display("FAIL write_bready got=%b exp=%b", flags, 7'b0000010);
    end
    master_bvalid = 1'b1; master_bresp = 2'b00;
    tick;
    master_bvalid = 1'b0;
    checks++;
    if ({flags, resp_rdata, resp_err} !== {7'b0000001, 32'h0, 1'b0}) begin
      failures++; $display("FAIL write_resp got=%b/%h/%b exp=0000001/00000000/0", flags, resp_rdata, resp_err);
    end
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
  endtask

  task automatic test_errors;
    issue(1'b0, 32'h0000_1000, 3'd2, 32'h0, 4'h0);
    master_arready = 1'b1;
    tick;
    master_arready = 1'b0;
    master_rvalid = 1'b1; master_rdata = 32'hCAFE_F00D; master_rresp = 2'b10;
    tick;
    master_rvalid = 1'b0; master_rdata = 32'h0; master_rresp = 2'b00;
    // Hold off the response and make sure everything stays put.
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({flags, resp_rdata, resp_err} !== {7'b0000001, 32'hCAFE_F00D, 1'b1}) begin
        failures++; $display("FAIL rresp_err_hold%0d got=%b/%h/%b exp=0000001/cafef00d/1", i, flags, resp_rdata, resp_err);
      end
      tick;
    end
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    checks++;
    if (flags !== 7'b1000000) begin
      failures++; $display("FAIL rresp_err_release got=%b exp=%b", flags, 7'b1000000);
    end
    issue(1'b1, 32'h0000_2000, 3'd2, 32'h1234_5678, 4'hF);
    master_awready = 1'b1; master_wready = 1'b1;
    tick;
    master_awready = 1'b0; master_wready = 1'b0;
    checks++;
    if (flags !== 7'b0000010) begin
      failures++; $display("FAIL write_same_cycle got=%b exp=%b", flags, 7'b0000010);
    end
    master_bvalid = 1'b1; master_bresp = 2'b11;
    tick;
    master_bvalid = 1'b0; master_bresp = 2'b00;
    checks++;
    if ({flags, resp_rdata, resp_err} !== {7'b0000001, 32'h0, 1'b1}) begin
      failures++; $display("FAIL bresp_err got=%b/%h/%b exp=0000001/00000000/1", flags, resp_rdata, resp_err);
    end
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
  endtask

  task automatic test_timeout;
    master_rdata = 32'h5555_AAAA;
    issue(1'b0, 32'h0000_3000, 3'd2, 32'h0, 4'h0);
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (flags !== 7'b0100000) begin
        failures++; $display("FAIL timeout_wait%0d got=%b exp=%b", i, flags, 7'b0100000);
      end
      tick;
    end
    checks++;
    if ({flags, resp_rdata, resp_err} !== {7'b0000001, 32'h0, 1'b1}) begin
      failures++; $display("FAIL timeout_resp got=%b/%h/%b exp=0000001/00000000/1", flags, resp_rdata, resp_err);
    end
    master_rdata = 32'h0;
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    issue(1'b0, 32'h0000_3004, 3'd2, 32'h0, 4'h0);
    master_arready = 1'b1;
    tick;
    master_arready = 1'b0;
    master_rvalid = 1'b1; master_rdata = 32'h1357_9BDF; master_rresp = 2'b00;
    tick;
    master_rvalid = 1'b0; master_rdata = 32'h0;
    checks++;
    if ({flags, resp_rdata, resp_err} !== {7'b0000001, 32'h1357_9BDF, 1'b0}) begin
      failures++; $display("FAIL after_timeout_read got=%b/%h/%b exp=0000001/13579bdf/0", flags, resp_rdata, resp_err);
    end
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    issue(1'b0, 32'h0000_4000, 3'd2, 32'h0, 4'h0);
    master_arready = 1'b1;
    tick;
    master_arready = 1'b0;
    checks++;
    if (flags !== 7'b0010000) begin
      failures++; $display("FAIL midreset_pre got=%b exp=%b", flags, 7'b0010000);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (flags !== 7'b0000000) begin
      failures++; $display("FAIL midreset_immediate got=%b exp=%b", flags, 7'b0000000);
    end
    tick;
    reset = 1'b0;
    tick;
    checks++;
    if (flags !== 7'b1000000) begin
      failures++; $display("FAIL midreset_release got=%b exp=%b", flags, 7'b1000000);
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_size = 3'd0;
    req_wdata = 32'h0; req_wstrb = 4'h0; resp_ready = 1'b0;
    master_awready = 1'b0; master_wready = 1'b0; master_bvalid = 1'b0; master_bresp = 2'b00;
    master_arready = 1'b0; master_rvalid = 1'b0; master_rdata = 32'h0; master_rresp = 2'b00;
    test_reset;
    test_read;
    test_write;
    test_errors;
    test_timeout;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_24110017_axi_master.md
YSYX_24110017_AXI_MASTER -- requirements
Module: ysyx_24110017_axi_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023, meaning cycles waited on any AXI channel before forcing an error response.
REQ-002 SHALL have clock  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have req_valid  input  1  core request valid.
REQ-005 SHALL have req_ready  output  1  request accepted when high with req_valid.
REQ-006 SHALL have req_wen  input  1  1=write, 0=read.
REQ-007 SHALL have req_addr  input  32  byte address.
REQ-008 SHALL have req_size  input  3  AXI size code, 0..2 legal.
REQ-009 SHALL have req_wdata  input  32  write data, lane-aligned.
REQ-010 SHALL have req_wstrb  input  4  write byte strobes.
REQ-011 SHALL have resp_valid  output  1  response valid.
REQ-012 SHALL have resp_ready  input  1  core accepts response.
REQ-013 SHALL have resp_rdata  output  32  read data, 0 for writes.
REQ-014 SHALL have resp_err  output  1  nonzero rresp/bresp, or timeout.
REQ-015 SHALL have master_awready  input  1  AW ready.
REQ-016 SHALL have master_awvalid  output  1  AW valid.
REQ-017 SHALL have master_awaddr  output  32  write address.
REQ-018 SHALL have master_awsize  output  3  write size.
REQ-019 SHALL have master_wready  input  1  W ready.
REQ-020 SHALL have master_wvalid  output  1  W valid.
REQ-021 SHALL have master_wdata  output  32  write data.
REQ-022 SHALL have master_wstrb  output  4  write strobes.
REQ-023 SHALL have master_bready  output  1  B ready.
REQ-024 SHALL have master_bvalid  input  1  B valid.
REQ-025 SHALL have master_bresp  input  2  write response.
REQ-026 SHALL have master_arready  input  1  AR ready.
REQ-027 SHALL have master_arvalid  output  1  AR valid.
REQ-028 SHALL have master_araddr  output  32  read address.
REQ-029 SHALL have master_arsize  output  3  read size.
REQ-030 SHALL have master_rready  output  1  R ready.
REQ-031 SHALL have master_rvalid  input  1  R valid.
REQ-032 SHALL have master_rdata  input  32  read data.
REQ-033 SHALL have master_rresp  input  2  read response.
Function
REQ-034 SHALL implement FSM IDLE, RADDR, RDATA, WADDR, WRESP, DONE; req_ready=1 only in IDLE; one transaction outstanding.
REQ-035 SHALL register addr/size/wdata/wstrb on the accept cycle T; the request bus is ignored after T.
REQ-036 Read: RADDR at T+1, arvalid=1, araddr/arsize stable until arready; then RDATA, rready=1; on rvalid capture rdata, err=(rresp!=0), go DONE.
REQ-037 Write: WADDR at T+1, awvalid and wvalid both 1; each drops independently after its own handshake (same-cycle or any order); when both done go WRESP, bready=1; on bvalid err=(bresp!=0), go DONE.
REQ-038 DONE: resp_valid=1, rdata/err held stable until resp_ready; then IDLE; req_ready returns the cycle after (no same-cycle reaccept).
REQ-039 Latency with zero-wait slave and rvalid k cycles after AR handshake: arvalid at T+1, resp_valid at T+3+k.
REQ-040 Timeout counter SHALL clear on request accept, count every non-IDLE/non-DONE cycle; reaching TIMEOUT SHALL drop all valids/readies, go DONE, resp_err=1, resp_rdata=0 (deliberate protocol abort, debug aid).
REQ-041 awid/arid=0, awlen/arlen=0, awburst/arburst=INCR, wlast=1 SHALL be tied by the instantiating top, not this block.
Reset
REQ-042 Reset SHALL immediately force IDLE, all outputs 0, counter 0, including mid-transaction (any asserted valid drops with no handshake).
Verification
REQ-043 Read 0x80000004, size 2, slave rvalid k=3, rdata 0x00100073, rresp 0 -> arvalid at T+1, resp_valid at T+6, rdata 0x00100073, err 0.
REQ-044 Write 0xa00003F8, wdata 0x41, wstrb 0001, awready 2 cycles before wready -> awvalid drops first, wvalid holds; bready only after both; resp err 0, rdata 0.
REQ-045 rresp=2'b10 on read -> resp_err=1, rdata captured; bresp=2'b11 on write -> resp_err=1.
REQ-046 TIMEOUT=8, arready held 0 -> arvalid drops after 8 cycles, resp_valid with err=1, rdata 0; next request then serviced normally.
REQ-047 resp_ready held 0 for 5 cycles in DONE -> resp outputs stable, req_ready 0; reset asserted during RDATA -> rready and resp_valid 0 immediately, req_ready 1 after release.
